// File: rtl/firebird7_in_gate1_tessent_tdr_w3_ctl.sv
// IJTAG capture/shift/update TDR driving the gate1 3-bit data mux select and data controls.
// Shift chain is {select image, data image}; the data LSB leaves first on ijtag_so.
module firebird7_in_gate1_tessent_tdr_w3_ctl #(
    parameter int unsigned      WIDTH        = 3,
    parameter logic [WIDTH-1:0] RESET_DATA   = 3'b000,
    parameter logic             RESET_SELECT = 1'b0
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out
);

    logic [WIDTH:0]   shift_q, shift_d;
    logic [WIDTH-1:0] upd_data_q, upd_data_d;
    logic             upd_sel_q, upd_sel_d;

    // Capture beats shift beats update; only one operation applies per edge.
    always_comb begin
        shift_d    = shift_q;
        upd_data_d = upd_data_q;
        upd_sel_d  = upd_sel_q;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                shift_d = {upd_sel_q, functional_data_in};
            end else if (ijtag_se) begin
                shift_d = {ijtag_si, shift_q[WIDTH:1]};
            end else if (ijtag_ue) begin
                upd_sel_d  = shift_q[WIDTH];
                upd_data_d = shift_q[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            shift_q    <= {RESET_SELECT, RESET_DATA};
            upd_data_q <= RESET_DATA;
            upd_sel_q  <= RESET_SELECT;
        end else begin
            shift_q    <= shift_d;
            upd_data_q <= upd_data_d;
            upd_sel_q  <= upd_sel_d;
        end
    end

    // Update registers feed the mux directly, so shifting never glitches its controls.
    assign ijtag_so       = shift_q[0];
    assign ijtag_select   = upd_sel_q;
    assign ijtag_data_out = upd_data_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w3_ctl.sv
// Directed bench for the gate1 TDR: driver pushes hand-computed {select, data, so}
// expectations into a queue and a negedge monitor pops and compares them.
module tb_firebird7_in_gate1_tessent_tdr_w3_ctl;

    localparam int W = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel, ce, se, ue, si;
    logic [2:0] fdi;
    logic       so, select_o;
    logic [2:0] data_o;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    firebird7_in_gate1_tessent_tdr_w3_ctl dut (
        .ijtag_tck          (clk),
        .ijtag_reset        (rst_n),
        .ijtag_sel          (sel),
        .ijtag_ce           (ce),
        .ijtag_se           (se),
        .ijtag_ue           (ue),
        .ijtag_si           (si),
        .ijtag_so           (so),
        .functional_data_in (fdi),
        .ijtag_select       (select_o),
        .ijtag_data_out     (data_o)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // driver: apply one cycle of inputs, then queue the expected post-edge outputs
    task automatic cyc(input logic r, input logic s, input logic c, input logic sh,
                       input logic u, input logic i, input logic [2:0] f,
                       input logic [W-1:0] exp_v, input string nm);
        rst_n = r; sel = s; ce = c; se = sh; ue = u; si = i; fdi = f;
        @(posedge clk);
        #1;
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {select_o, data_o, so};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL %s: got {sel,data,so}=%b required %b", nm, a, e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0; fdi = 3'b000;
        @(negedge clk);

        // reset with random enables
        for (int k = 0; k < 2; k++)
            cyc(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)),
                5'b0_000_0, "reset");

        // load 1,0,1,1 then update
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 5'b0_000_0, "load_sh1");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 5'b0_000_0, "load_sh2");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 5'b0_000_0, "load_sh3");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 5'b0_000_1, "load_sh4");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 5'b1_101_1, "update");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 5'b1_101_1, "update_again");

        // capture read-back of 110 with select=1
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 5'b1_101_0, "cap");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 5'b1_101_1, "cap_sh1");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 5'b1_101_1, "cap_sh2");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 5'b1_101_1, "cap_sh3");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 5'b1_101_0, "cap_sh4");

        // priority: capture wins over shift and update -> chain 1011
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b011, 5'b1_101_1, "priority");

        // deselected: everything holds
        for (int k = 0; k < 5; k++)
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'(k % 2), 3'($urandom_range(7)),
                5'b1_101_1, "deselect");

        // unload chain 1011 to prove it was untouched
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 5'b1_101_1, "unload1");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 5'b1_101_0, "unload2");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 5'b1_101_1, "unload3");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 5'b1_101_0, "unload4");

        // reset mid-shift, then update must not expose partial content
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 5'b1_101_0, "mid_sh1");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 5'b1_101_0, "mid_sh2");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 5'b0_000_0, "mid_reset");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 5'b0_000_0, "post_reset_upd");

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
